// File: rtl/rhythm_window_analyzer.sv
// rhythm_window_analyzer
//   Rolling-window rhythm analyser. Each accepted beat's 2-bit class goes into
//   a circular window of WIN_DEPTH entries. Per-class counts are maintained
//   incrementally. On a full-window beat, or on a forced request, the counts
//   are snapshotted and the dominant class is picked. A restoring divider then
//   normalises the dominant count to the number of beats held.
//
//   Ports
//     clk, rst       clock, synchronous active-high reset
//     beat_valid     one beat accepted this cycle, class on beat_class
//     force_anlz     level; a rising edge requests analysis (fill >= MIN_BEATS)
//     clear          flush window, abort analysis, keep last result
//     final_diag     dominant class (00 normal, 01 brady, 10 tachy, 11 irreg)
//     confidence     floor(dom_count * (2^CONF_W-1) / fill)
//     diag_valid     one-cycle pulse when final_diag/confidence update
//     busy           analysis in progress
//     fill_count     beats held, saturates at WIN_DEPTH
//     class_counts   {irreg, tachy, brady, normal}, CNT_W bits each
//
//   Build option
//     ANLZ_HYST_EN   when defined, the reported class changes only if the new
//                    dominant count strictly beats the current class's count.
module rhythm_window_analyzer #(
    parameter int  WIN_DEPTH = 8,
    parameter int  MIN_BEATS = 4,
    parameter int  CONF_W    = 8,
    localparam int CNT_W     = $clog2(WIN_DEPTH + 1),
    localparam int NUM_W     = CNT_W + CONF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               beat_valid,
    input  logic [1:0]         beat_class,
    input  logic               force_anlz,
    input  logic               clear,
    output logic [1:0]         final_diag,
    output logic [CONF_W-1:0]  confidence,
    output logic               diag_valid,
    output logic               busy,
    output logic [CNT_W-1:0]   fill_count,
    output logic [4*CNT_W-1:0] class_counts
);

    localparam int                PTR_W     = $clog2(WIN_DEPTH);
    localparam int                STEP_W    = $clog2(NUM_W + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(WIN_DEPTH);
    localparam logic [CNT_W-1:0]  MIN_C     = CNT_W'(MIN_BEATS);
    localparam logic [NUM_W-1:0]  SCALE_C   = NUM_W'((1 << CONF_W) - 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NUM_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_DONE
    } state_t;

    // Window storage and counters
    logic [1:0]        win_q [WIN_DEPTH];
    logic [PTR_W-1:0]  wptr_q;
    logic [CNT_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic              force_prev_q;

    // Control
    state_t            state_q, state_d;
    logic              pending_q, pending_d;
    logic              snap_load;

    // Analysis datapath
    logic [CNT_W-1:0]  snap_cnt_q [4];
    logic [CNT_W-1:0]  snap_fill_q;
    logic [STEP_W-1:0] step_q;
    logic [NUM_W-1:0]  dvd_q;
    logic [CNT_W-1:0]  rem_q;
    logic [CONF_W-1:0] quo_q;
    logic [1:0]        dom_q;

    // Result registers
    logic [1:0]        final_diag_q;
    logic [CONF_W-1:0] conf_q;
    logic              diag_valid_q;

    logic              win_full;
    logic [1:0]        evict_cls;
    logic              beat_trig, force_trig, trig;

    assign win_full  = (fill_q == DEPTH_C);
    assign evict_cls = win_q[wptr_q];

    // Next-state counts. When full, the entry under the write pointer is the
    // oldest beat and leaves the window; a same-class replace is a no-op.
    always_comb begin
        fill_d = fill_q;
        for (int c = 0; c < 4; c++) cnt_d[c] = cnt_q[c];
        if (clear) begin
            fill_d = '0;
            for (int c = 0; c < 4; c++) cnt_d[c] = '0;
        end else if (beat_valid) begin
            if (!win_full) fill_d = fill_q + CNT_W'(1);
            for (int c = 0; c < 4; c++) begin
                if (beat_class == 2'(c) && !(win_full && evict_cls == 2'(c)))
                    cnt_d[c] = cnt_q[c] + CNT_W'(1);
                else if (beat_class != 2'(c) && win_full && evict_cls == 2'(c))
                    cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end
        end
    end

    // Beat trigger looks at the post-update fill; force uses the current fill.
    assign beat_trig  = beat_valid && !clear && (fill_d == DEPTH_C);
    assign force_trig = force_anlz && !force_prev_q && !clear && (fill_q >= MIN_C);
    assign trig       = beat_trig || force_trig;

    // Dominant class from the snapshot; later classes win ties.
    logic [1:0] new_dom, sel_dom;
    always_comb begin
        new_dom = 2'd0;
        for (int c = 1; c < 4; c++)
            if (snap_cnt_q[c] >= snap_cnt_q[new_dom]) new_dom = 2'(c);
    end

`ifdef ANLZ_HYST_EN
    assign sel_dom = (snap_cnt_q[new_dom] > snap_cnt_q[final_diag_q]) ? new_dom : final_diag_q;
`else
    assign sel_dom = new_dom;
`endif

    // One restoring-division step. The quotient always fits CONF_W bits
    // (dom_count <= fill), so only the low CONF_W quotient bits are kept.
    logic [CNT_W:0]    rem_sh;
    logic              rem_ge;
    logic [CNT_W-1:0]  rem_nx;
    logic [CONF_W-1:0] quo_nx;

    assign rem_sh = {rem_q, dvd_q[NUM_W-1]};
    assign rem_ge = (rem_sh >= {1'b0, snap_fill_q});
    assign rem_nx = rem_ge ? CNT_W'(rem_sh - {1'b0, snap_fill_q}) : rem_sh[CNT_W-1:0];
    assign quo_nx = (quo_q << 1) | CONF_W'(rem_ge);

    // FSM. DIV step 0 sets up the dividend, steps 1..NUM_W produce quotient
    // bits, which lands DONE exactly NUM_W+2 cycles after the trigger.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        snap_load = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (trig) begin
                    state_d   = S_DIV;
                    snap_load = 1'b1;
                end
            end
            S_DIV: begin
                if (trig) pending_d = 1'b1;
                if (step_q == LAST_STEP) state_d = S_DONE;
            end
            S_DONE: begin
                if (pending_q || trig) begin
                    state_d   = S_DIV;
                    snap_load = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
                pending_d = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d   = S_IDLE;
            pending_d = 1'b0;
            snap_load = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIN_DEPTH; i++) win_q[i] <= 2'b00;
            wptr_q       <= '0;
            fill_q       <= '0;
            for (int c = 0; c < 4; c++) begin
                cnt_q[c]      <= '0;
                snap_cnt_q[c] <= '0;
            end
            force_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            pending_q    <= 1'b0;
            snap_fill_q  <= '0;
            step_q       <= '0;
            dvd_q        <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            dom_q        <= 2'b00;
            final_diag_q <= 2'b00;
            conf_q       <= '0;
            diag_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            force_prev_q <= force_anlz;
            fill_q       <= fill_d;
            for (int c = 0; c < 4; c++) cnt_q[c] <= cnt_d[c];

            if (clear) begin
                wptr_q <= '0;
            end else if (beat_valid) begin
                win_q[wptr_q] <= beat_class;
                wptr_q        <= wptr_q + PTR_W'(1);
            end

            // Snapshot takes next-state counts so it matches trigger+1 values.
            if (snap_load) begin
                for (int c = 0; c < 4; c++) snap_cnt_q[c] <= cnt_d[c];
                snap_fill_q <= fill_d;
                step_q      <= '0;
            end else if (state_q == S_DIV) begin
                step_q <= step_q + STEP_W'(1);
                if (step_q == '0) begin
                    dvd_q <= NUM_W'(snap_cnt_q[sel_dom]) * SCALE_C;
                    rem_q <= '0;
                    quo_q <= '0;
                    dom_q <= sel_dom;
                end else begin
                    dvd_q <= dvd_q << 1;
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                end
            end

            diag_valid_q <= 1'b0;
            if (state_q == S_DIV && step_q == LAST_STEP && !clear) begin
                final_diag_q <= dom_q;
                conf_q       <= quo_nx;
                diag_valid_q <= 1'b1;
            end
        end
    end

    assign final_diag   = final_diag_q;
    assign confidence   = conf_q;
    assign diag_valid   = diag_valid_q;
    assign busy         = (state_q != S_IDLE);
    assign fill_count   = fill_q;
    assign class_counts = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule
